// File: rtl/pixel_array_ctrl_pkg.sv
// Shared types and helpers for the pixel array sequencer.
// Holds the controller state encoding, the default code width and
// the binary/Gray conversion functions used by the counter and capture path.
package pixel_ctrl_pkg;

    localparam int PIX_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ERASE   = 3'd1,
        ST_EXPOSE  = 3'd2,
        ST_CONVERT = 3'd3,
        ST_RD12    = 3'd4,
        ST_OUT12   = 3'd5,
        ST_RD34    = 3'd6,
        ST_OUT34   = 3'd7
    } ctrl_state_t;

    function automatic logic [PIX_W-1:0] bin2gray(input logic [PIX_W-1:0] bin_s);
        return bin_s ^ (bin_s >> 1);
    endfunction

    function automatic logic [PIX_W-1:0] gray2bin(input logic [PIX_W-1:0] gray_s);
        logic [PIX_W-1:0] bin_s;
        bin_s = gray_s;
        for (int i = PIX_W - 2; i >= 0; i--) begin
            bin_s[i] = bin_s[i+1] ^ gray_s[i];
        end
        return bin_s;
    endfunction

endpackage

// File: rtl/pixel_array_ctrl_if.sv
// Ready/valid pixel stream leaving the sequencer.
// master = producer (sequencer), slave = downstream consumer.
interface pixel_array_ctrl_if
    import pixel_ctrl_pkg::*;
#(
    parameter int W = PIX_W
);
    logic [W-1:0] pix_data;
    logic [1:0]   pix_idx;
    logic         pix_valid;
    logic         pix_ready;

    modport master (output pix_data, output pix_idx, output pix_valid, input pix_ready);
    modport slave  (input pix_data, input pix_idx, input pix_valid, output pix_ready);
endinterface

// File: rtl/pixel_array_ctrl_conv_counter.sv
// Ramp counter for the CONVERT phase.
// Counts while enabled, clears on request, flags the terminal count.
// With GRAY_COUNT_EN defined the bus code is Gray, otherwise plain binary.
module conv_counter
    import pixel_ctrl_pkg::*;
#(
    parameter int W = PIX_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt_code,
    output logic         tc
);

    logic [W-1:0] count_r;
    logic [W-1:0] count_s;
    logic [W-1:0] code_s;
    logic [W-1:0] code_r;

    // Next count value: clear dominates, then increment when enabled.
    always_comb begin
        count_s = count_r;
        if (clr) begin
            count_s = {W{1'b0}};
        end else if (en) begin
            count_s = count_r + W'(1);
        end else begin
            count_s = count_r;
        end
    end

    // Bus encoding of the next count, so the code register tracks the count register.
    always_comb begin
`ifdef GRAY_COUNT_EN
        code_s = W'(bin2gray(PIX_W'(count_s)));
`else
        code_s = count_s;
`endif
    end

    // Count and encoded-code registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {W{1'b0}};
            code_r  <= {W{1'b0}};
        end else begin
            count_r <= count_s;
            code_r  <= code_s;
        end
    end

    assign cnt_code = code_r;
    assign tc       = (count_r == {W{1'b1}});

endmodule

// File: rtl/pixel_array_ctrl.sv
// Sequencer for the 2x2 pixel sensor array: erase, expose, ramp convert,
// two read phases and a ready/valid pixel stream of the four codes.
// Optional build macro: GRAY_COUNT_EN (Gray ramp on the bus, Gray decode on capture).
// RD12 opens with one guard cycle with READ12 low so the array never drives
// the data buses in the cycle right after the counter released them.
module pixel_array_ctrl
    import pixel_ctrl_pkg::*;
#(
    parameter int W         = PIX_W,
    parameter int ERASE_CYC = 5,
    parameter int READ_CYC  = 2,
    parameter int ETW       = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [ETW-1:0] expose_time,
    output logic           erase,
    output logic           expose,
    output logic           convert,
    output logic [W-1:0]   cnt_out,
    output logic           cnt_oe,
    output logic           read12,
    output logic           read34,
    input  logic [W-1:0]   data_in1,
    input  logic [W-1:0]   data_in2,
    input  logic [W-1:0]   data_in3,
    input  logic [W-1:0]   data_in4,
    output logic           busy,
    output logic           done,
    pixel_array_ctrl_if.master pix
);

    localparam int CYC_W = (ETW > 8) ? ETW : 8;

    localparam logic [2:0] S_IDLE    = 3'(ST_IDLE);
    localparam logic [2:0] S_ERASE   = 3'(ST_ERASE);
    localparam logic [2:0] S_EXPOSE  = 3'(ST_EXPOSE);
    localparam logic [2:0] S_CONVERT = 3'(ST_CONVERT);
    localparam logic [2:0] S_RD12    = 3'(ST_RD12);
    localparam logic [2:0] S_OUT12   = 3'(ST_OUT12);
    localparam logic [2:0] S_RD34    = 3'(ST_RD34);
    localparam logic [2:0] S_OUT34   = 3'(ST_OUT34);

    logic [2:0]       state_r, state_s;
    logic [CYC_W-1:0] cyc_r, cyc_s;
    logic [ETW-1:0]   exp_r, exp_s;

    logic             erase_r, expose_r, convert_r, cnt_oe_r;
    logic             read12_r, read34_r, busy_r, done_r;

    logic [W-1:0]     pix_data_r;
    logic [1:0]       pix_idx_r;
    logic             pix_valid_r;
    logic [W-1:0]     hold_r;
    logic             sel_r;
    logic             xfer_s;

    logic             cnt_en_s, cnt_clr_s, cnt_tc_s;
    logic [W-1:0]     cnt_code_s;
    logic [W-1:0]     dec1_s, dec2_s, dec3_s, dec4_s;

    assign xfer_s    = pix_valid_r & pix.pix_ready;
    assign cnt_en_s  = (state_r == S_CONVERT);
    assign cnt_clr_s = (state_r != S_CONVERT) | cnt_tc_s;

    conv_counter #(.W(W)) u_conv_counter (
        .clk      (clk),
        .reset    (reset),
        .en       (cnt_en_s),
        .clr      (cnt_clr_s),
        .cnt_code (cnt_code_s),
        .tc       (cnt_tc_s)
    );

    // Convert the observed bus values into binary pixel codes.
    always_comb begin
`ifdef GRAY_COUNT_EN
        dec1_s = W'(gray2bin(PIX_W'(data_in1)));
        dec2_s = W'(gray2bin(PIX_W'(data_in2)));
        dec3_s = W'(gray2bin(PIX_W'(data_in3)));
        dec4_s = W'(gray2bin(PIX_W'(data_in4)));
`else
        dec1_s = data_in1;
        dec2_s = data_in2;
        dec3_s = data_in3;
        dec4_s = data_in4;
`endif
    end

    // Next-state, phase-cycle counter and exposure latch.
    always_comb begin
        state_s = state_r;
        cyc_s   = cyc_r;
        exp_s   = exp_r;
        case (state_r)
            S_IDLE: begin
                cyc_s = {CYC_W{1'b0}};
                if (start && !done_r) begin
                    state_s = S_ERASE;
                    exp_s   = (expose_time == {ETW{1'b0}}) ? ETW'(1) : expose_time;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ERASE: begin
                if (cyc_r == CYC_W'(ERASE_CYC - 1)) begin
                    state_s = S_EXPOSE;
                    cyc_s   = {CYC_W{1'b0}};
                end else begin
                    cyc_s = cyc_r + CYC_W'(1);
                end
            end
            S_EXPOSE: begin
                if ((cyc_r + CYC_W'(1)) == CYC_W'(exp_r)) begin
                    state_s = S_CONVERT;
                    cyc_s   = {CYC_W{1'b0}};
                end else begin
                    cyc_s = cyc_r + CYC_W'(1);
                end
            end
            S_CONVERT: begin
                if (cnt_tc_s) begin
                    state_s = S_RD12;
                    cyc_s   = {CYC_W{1'b0}};
                end else begin
                    state_s = S_CONVERT;
                end
            end
            S_RD12: begin
                if (cyc_r == CYC_W'(READ_CYC)) begin
                    state_s = S_OUT12;
                    cyc_s   = {CYC_W{1'b0}};
                end else begin
                    cyc_s = cyc_r + CYC_W'(1);
                end
            end
            S_OUT12: begin
                if (xfer_s && sel_r) begin
                    state_s = S_RD34;
                end else begin
                    state_s = S_OUT12;
                end
            end
            S_RD34: begin
                if (cyc_r == CYC_W'(READ_CYC - 1)) begin
                    state_s = S_OUT34;
                    cyc_s   = {CYC_W{1'b0}};
                end else begin
                    cyc_s = cyc_r + CYC_W'(1);
                end
            end
            S_OUT34: begin
                if (xfer_s && sel_r) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_OUT34;
                end
            end
            default: begin
                state_s = S_IDLE;
                cyc_s   = {CYC_W{1'b0}};
            end
        endcase
    end

    // State register and array control strobes, decoded from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= S_IDLE;
            cyc_r     <= {CYC_W{1'b0}};
            exp_r     <= {ETW{1'b0}};
            erase_r   <= 1'b0;
            expose_r  <= 1'b0;
            convert_r <= 1'b0;
            cnt_oe_r  <= 1'b0;
            read12_r  <= 1'b0;
            read34_r  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cyc_r     <= cyc_s;
            exp_r     <= exp_s;
            erase_r   <= (state_s == S_ERASE);
            expose_r  <= (state_s == S_EXPOSE);
            convert_r <= (state_s == S_CONVERT);
            cnt_oe_r  <= (state_s == S_CONVERT);
            read12_r  <= (state_s == S_RD12) && (cyc_s != {CYC_W{1'b0}});
            read34_r  <= (state_s == S_RD34);
            busy_r    <= (state_s != S_IDLE);
            done_r    <= (state_r == S_OUT34) && (state_s == S_IDLE);
        end
    end

    // Capture a read pair and stream it out entry by entry on ready/valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_valid_r <= 1'b0;
            pix_data_r  <= {W{1'b0}};
            pix_idx_r   <= 2'd0;
            hold_r      <= {W{1'b0}};
            sel_r       <= 1'b0;
        end else if ((state_r == S_RD12) && (state_s == S_OUT12)) begin
            pix_valid_r <= 1'b1;
            pix_data_r  <= dec1_s;
            pix_idx_r   <= 2'd0;
            hold_r      <= dec2_s;
            sel_r       <= 1'b0;
        end else if ((state_r == S_RD34) && (state_s == S_OUT34)) begin
            pix_valid_r <= 1'b1;
            pix_data_r  <= dec3_s;
            pix_idx_r   <= 2'd2;
            hold_r      <= dec4_s;
            sel_r       <= 1'b0;
        end else if (xfer_s && !sel_r) begin
            pix_data_r  <= hold_r;
            pix_idx_r   <= pix_idx_r + 2'd1;
            sel_r       <= 1'b1;
        end else if (xfer_s) begin
            pix_valid_r <= 1'b0;
            pix_data_r  <= {W{1'b0}};
            pix_idx_r   <= 2'd0;
            sel_r       <= 1'b0;
        end else begin
            pix_valid_r <= pix_valid_r;
        end
    end

    assign erase         = erase_r;
    assign expose        = expose_r;
    assign convert       = convert_r;
    assign cnt_out       = cnt_code_s;
    assign cnt_oe        = cnt_oe_r;
    assign read12        = read12_r;
    assign read34        = read34_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign pix.pix_data  = pix_data_r;
    assign pix.pix_idx   = pix_idx_r;
    assign pix.pix_valid = pix_valid_r;

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Self-checking bench for pixel_array_ctrl: a behavioural array/bus model
// latches the ramp code at chosen counts and a frame-level model checks phase
// lengths, ordering, bus exclusivity, stream content and handshake stability.
// Honours GRAY_COUNT_EN for the expected ramp code.
module tb_pixel_array_ctrl;

    localparam int W         = 8;
    localparam int ERASE_CYC = 5;
    localparam int READ_CYC  = 2;
    localparam int NCONV     = 256;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] expose_time;
    logic       erase, expose, convert, cnt_oe, read12, read34, busy, done;
    logic [7:0] cnt_out;
    logic [7:0] data_in1, data_in2, data_in3, data_in4;

    pixel_array_ctrl_if #(.W(W)) pix_if ();

    pixel_array_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .expose_time(expose_time),
        .erase(erase), .expose(expose), .convert(convert), .cnt_out(cnt_out),
        .cnt_oe(cnt_oe), .read12(read12), .read34(read34),
        .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3), .data_in4(data_in4),
        .busy(busy), .done(done), .pix(pix_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
        end
    endtask

    function automatic int enc(input int k);
`ifdef GRAY_COUNT_EN
        return k ^ (k >> 1);
`else
        return k;
`endif
    endfunction

    // model state
    int   lv[4];
    int   ready_mode;
    bit   in_frame;
    int   fc, frames_started, frames_done;
    int   erase_n, expose_n, convert_n, cntoe_n, read12_n, read34_n;
    int   t_erase, t_expose, t_convert, t_rd34, t_x1, cnt_at5;
    int   cnt_err, overlap_err, stab_err, busy_err, stray_done;
    int   xfer_data[$];
    int   xfer_idx[$];
    logic [7:0] latched[4];
    bit   prev_cnt_oe, prev_valid, prev_ready;
    int   prev_data, prev_idx;
    int   stall_n;

    // Mid-cycle monitor, array bus model and stream consumer.
    always @(negedge clk) begin
        if (reset) begin
            in_frame = 1'b0;
            prev_valid = 1'b0;
            prev_cnt_oe = 1'b0;
            pix_if.pix_ready = 1'b0;
            data_in1 = 8'h00; data_in2 = 8'h00; data_in3 = 8'h00; data_in4 = 8'h00;
        end else begin
            // consumer decision for the coming edge
            case (ready_mode)
                0: pix_if.pix_ready = 1'b1;
                1: pix_if.pix_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (pix_if.pix_valid && pix_if.pix_idx == 2'd1 && stall_n < 3) begin
                        pix_if.pix_ready = 1'b0;
                        stall_n++;
                    end else begin
                        pix_if.pix_ready = 1'b1;
                    end
                end
            endcase

            if (busy !== (in_frame && !done)) busy_err++;
            if (done && !in_frame) stray_done++;

            if (in_frame) begin
                if (erase)   begin if (t_erase < 0)   t_erase = fc;   erase_n++;   end
                if (expose)  begin if (t_expose < 0)  t_expose = fc;  expose_n++;  end
                if (convert) begin if (t_convert < 0) t_convert = fc; convert_n++; end
                if (read12)  read12_n++;
                if (read34)  begin if (t_rd34 < 0) t_rd34 = fc; read34_n++; end
                if (cnt_oe) begin
                    if (int'(cnt_out) != enc(cntoe_n)) cnt_err++;
                    if (cntoe_n == 5) cnt_at5 = int'(cnt_out);
                    for (int p = 0; p < 4; p++) if (lv[p] == cntoe_n) latched[p] = cnt_out;
                    cntoe_n++;
                end else if (cnt_out !== 8'h00) begin
                    cnt_err++;
                end
                if (cnt_oe && (read12 || read34)) overlap_err++;
                if ((read12 || read34) && prev_cnt_oe) overlap_err++;
                if (prev_valid && !prev_ready &&
                    (!pix_if.pix_valid || int'(pix_if.pix_data) != prev_data ||
                     int'(pix_if.pix_idx) != prev_idx)) stab_err++;
                if (pix_if.pix_valid && pix_if.pix_ready) begin
                    xfer_data.push_back(int'(pix_if.pix_data));
                    xfer_idx.push_back(int'(pix_if.pix_idx));
                    if (pix_if.pix_idx == 2'd1) t_x1 = fc;
                end
                prev_cnt_oe = cnt_oe;
                prev_valid  = pix_if.pix_valid;
                prev_ready  = pix_if.pix_ready;
                prev_data   = int'(pix_if.pix_data);
                prev_idx    = int'(pix_if.pix_idx);
                fc++;
            end

            if (done && in_frame) begin
                in_frame = 1'b0;
                frames_done++;
            end

            if (start && !in_frame && !done) begin
                in_frame = 1'b1;
                frames_started++;
                fc = 0; erase_n = 0; expose_n = 0; convert_n = 0; cntoe_n = 0;
                read12_n = 0; read34_n = 0; stall_n = 0; cnt_at5 = -1;
                t_erase = -1; t_expose = -1; t_convert = -1; t_rd34 = -1; t_x1 = -1;
                xfer_data.delete(); xfer_idx.delete();
                prev_cnt_oe = 1'b0; prev_valid = 1'b0;
            end

            data_in1 = read12 ? latched[0] : 8'($urandom);
            data_in2 = read12 ? latched[1] : 8'($urandom);
            data_in3 = read34 ? latched[2] : 8'($urandom);
            data_in4 = read34 ? latched[3] : 8'($urandom);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic int outs_vec();
        return int'({erase, expose, convert, cnt_oe, read12, read34, busy, done,
                     pix_if.pix_valid, cnt_out, pix_if.pix_data, pix_if.pix_idx});
    endfunction

    task automatic run_frame(input int et, input int mode, input bit hold_start, input string nm);
        int d0, s0, ep;
        ready_mode = mode;
        d0 = frames_done;
        s0 = frames_started;
        ep = (et == 0) ? 1 : et;
        start = 1'b1;
        expose_time = 8'(et);
        tick();
        start = 1'b0;
        expose_time = 8'($urandom);
        for (int i = 0; i < 3000 && frames_done == d0; i++) begin
            if (hold_start && convert) start = 1'b1;
            tick();
        end
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check_eq({nm, "_started"}, frames_started - s0, 1);
        check_eq({nm, "_done"}, frames_done - d0, 1);
        check_eq({nm, "_t_erase"}, t_erase, 0);
        check_eq({nm, "_erase_len"}, erase_n, ERASE_CYC);
        check_eq({nm, "_t_expose"}, t_expose, ERASE_CYC);
        check_eq({nm, "_expose_len"}, expose_n, ep);
        check_eq({nm, "_t_convert"}, t_convert, ERASE_CYC + ep);
        check_eq({nm, "_convert_len"}, convert_n, NCONV);
        check_eq({nm, "_cntoe_len"}, cntoe_n, NCONV);
        check_eq({nm, "_cnt_seq_err"}, cnt_err, 0);
        check_eq({nm, "_cnt_at_5"}, cnt_at5, enc(5));
        check_eq({nm, "_read12_len"}, read12_n, READ_CYC);
        check_eq({nm, "_read34_len"}, read34_n, READ_CYC);
        check_eq({nm, "_overlap"}, overlap_err, 0);
        check_eq({nm, "_stable"}, stab_err, 0);
        check_eq({nm, "_busy"}, busy_err, 0);
        check_eq({nm, "_stray_done"}, stray_done, 0);
        check_eq({nm, "_rd34_after_x1"}, int'(t_rd34 > t_x1 && t_x1 >= 0), 1);
        check_eq({nm, "_xfer_n"}, xfer_data.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < xfer_data.size()) begin
                check_eq($sformatf("%s_idx%0d", nm, i), xfer_idx[i], i);
                check_eq($sformatf("%s_data%0d", nm, i), xfer_data[i], lv[i]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        expose_time = 8'h00;
        ready_mode = 0;
        in_frame = 1'b0;
        frames_started = 0; frames_done = 0;
        cnt_err = 0; overlap_err = 0; stab_err = 0; busy_err = 0; stray_done = 0;
        for (int p = 0; p < 4; p++) begin lv[p] = 0; latched[p] = 8'h00; end
        tick(); tick(); tick();
        check_eq("reset_outputs", outs_vec(), 0);
        reset = 1'b0;
        tick(); tick();
        check_eq("idle_busy", int'(busy), 0);

        // nominal frame with fixed latch counts
        lv[0] = 8'h00; lv[1] = 8'h7F; lv[2] = 8'hFF; lv[3] = 8'h3C;
        run_frame(10, 0, 1'b0, "nominal");

        // backpressure on idx 1
        lv[0] = int'($urandom_range(0, 255)); lv[1] = 5;
        lv[2] = int'($urandom_range(0, 255)); lv[3] = int'($urandom_range(0, 255));
        run_frame(7, 2, 1'b0, "stall");

        // zero exposure, START held from CONVERT through DONE
        for (int p = 0; p < 4; p++) lv[p] = int'($urandom_range(0, 255));
        run_frame(0, 1, 1'b1, "exp0");

        // reset in the middle of CONVERT
        ready_mode = 1;
        start = 1'b1;
        expose_time = 8'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 1000 && !(in_frame && cntoe_n >= 64); i++) tick();
        check_eq("rst_reach_0x40", cntoe_n, 64);
        check_eq("rst_cnt_at_0x40", int'(cnt_out), enc(64));
        #1 reset = 1'b1;
        #1 check_eq("rst_midframe_outputs", outs_vec(), 0);
        tick(); tick();
        reset = 1'b0;
        tick(); tick();
        check_eq("rst_after_busy", int'(busy), 0);
        check_eq("rst_after_valid", int'(pix_if.pix_valid), 0);
        for (int p = 0; p < 4; p++) lv[p] = int'($urandom_range(0, 255));
        run_frame(int'($urandom_range(1, 20)), 1, 1'b0, "post_rst");

        // random frames
        for (int f = 0; f < 3; f++) begin
            for (int p = 0; p < 4; p++) lv[p] = int'($urandom_range(0, 255));
            run_frame(int'($urandom_range(0, 30)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                      $sformatf("rand%0d", f));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pixel_array_ctrl.md
Name: pixel_array_ctrl

Overview:
- Sequencer for the 2x2 pixel sensor array; sits directly upstream of it.
- Drives the array's ERASE, EXPOSE, CONVERT (ramp-enable), READ12 and READ34 controls.
- Drives the conversion counter onto the pixel data buses during CONVERT.
- Captures the latched pixel codes during the read phases and streams them out as a ready/valid pixel stream.

Parameters:
- W, 8, pixel code / counter width.
- ERASE_CYC, 5, ERASE pulse length in clk cycles.
- READ_CYC, 2, cycles each READ strobe is held; data is sampled on the last one.
- ETW, 8, width of the EXPOSE_TIME input.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high controller reset (not the pixel analog RESET).
- START  in  1  begin one frame; sampled only in IDLE.
- EXPOSE_TIME  in  ETW  exposure length in cycles; sampled at START; 0 is treated as 1.
- ERASE  out  1  to array.
- EXPOSE  out  1  to array.
- CONVERT  out  1  ramp running; comparators armed.
- CNT_OUT  out  W  counter value for the pixel data buses.
- CNT_OE  out  1  tristate enable for CNT_OUT onto DATA1..4.
- READ12  out  1  to array; pixels 1 and 2 drive DATA1 and DATA2.
- READ34  out  1  to array; pixels 3 and 4 drive DATA3 and DATA4.
- DATA_IN1..DATA_IN4  in  W each  observed values of the array buses.
- PIX_DATA  out  W  pixel code.
- PIX_IDX  out  2  pixel index 0..3.
- PIX_VALID  out  1  stream valid.
- PIX_READY  in  1  stream ready.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse at frame end.

Behaviour:
- One clock domain, clk; reset is asynchronous and active-high. All outputs are registered.
- Reset forces state IDLE and all outputs to 0; this applies mid-frame too, with no partial stream completion.
- States: IDLE -> ERASE -> EXPOSE -> CONVERT -> RD12 -> OUT12 -> RD34 -> OUT34 -> IDLE.
- IDLE:
  - START=1 at an edge gives ERASE=1 from the next cycle.
  - EXPOSE_TIME is latched at that edge. START in any other state is ignored.
- ERASE: ERASE=1 for exactly ERASE_CYC cycles.
- EXPOSE: EXPOSE=1 for max(EXPOSE_TIME,1) cycles.
- CONVERT:
  - CONVERT=1 and CNT_OE=1 for exactly 2^W cycles.
  - CNT_OUT = 0,1,...,2^W-1, one value per cycle. The counter does not wrap within the phase.
  - CNT_OUT returns to 0 on exit.
- RD12 / RD34:
  - The READ strobe is high for READ_CYC cycles.
  - On the last cycle, DATA_IN1/2 (or DATA_IN3/4) are captured into a 2-entry buffer.
- Bus-contention invariant: CNT_OE and (READ12|READ34) are never high in the same cycle. Any READ is separated from CNT_OE by at least one cycle.
- OUT12 / OUT34:
  - Present the buffered entries in order, idx 0 then 1 (or 2 then 3).
  - PIX_VALID stays high and PIX_DATA/PIX_IDX stay stable until PIX_READY=1. Transfer happens on VALID&READY.
  - A new entry is presented the cycle after a transfer, with no bubble.
  - The state advances after the second transfer.
  - PIX_READY may be tied high; OUT12 then takes exactly 2 cycles.
- DONE=1 for one cycle on the OUT34 -> IDLE transition, concurrent with BUSY dropping.
- A START sampled in the same cycle DONE is high is ignored. A new frame needs START in IDLE.

Optional Feature:
- Macro: GRAY_COUNT_EN.
- Defined:
  - CNT_OUT carries the Gray code of the count.
  - Captured DATA_IN values are Gray-decoded to binary before PIX_DATA.
- Undefined:
  - CNT_OUT and PIX_DATA are plain binary; no decoder logic is present.

Decomposition:
- Package pixel_ctrl_pkg holds:
  - state enum ctrl_state_t.
  - W default constant.
  - bin2gray / gray2bin functions.
- One sub-module, conv_counter:
  - W-bit counter with enable and clear.
  - Binary or Gray output selected by GRAY_COUNT_EN.
  - Asserts a terminal-count flag at 2^W-1.

Test Plan:
1. Nominal frame: EXPOSE_TIME=10, START pulse, READY=1.
   - Expect ERASE 5 cycles, EXPOSE 10 cycles, CONVERT 256 cycles.
   - Expect READ12 then READ34 at 2 cycles each, 4 pixels idx 0..3, DONE pulse.
   - Expect BUSY high from the cycle after START through DONE.
2. Bus model: array latches at counts 0x00, 0x7F, 0xFF, 0x3C.
   - Expect PIX_DATA 0x00, 0x7F, 0xFF, 0x3C in idx order.
   - Check CNT_OE never overlaps READ12 or READ34.
3. Backpressure: READY low for 3 cycles on idx 1.
   - Expect VALID, data and idx held stable throughout, no loss or duplication; RD34 starts only after the idx-1 transfer.
4. EXPOSE_TIME=0 -> EXPOSE high exactly 1 cycle. START pulsed during CONVERT -> ignored; exactly one DONE.
5. Reset asserted mid-CONVERT at count 0x40.
   - Expect immediate return to all-zero outputs with BUSY=0 and no PIX_VALID.
   - A new START runs a full, correct frame.
6. GRAY_COUNT_EN defined: CNT_OUT at count 5 = 0x07; latched Gray 0x07 -> PIX_DATA 0x05.
